// File: rtl/mul_64b_prod_acc.sv
// Block accumulator for 128-bit unsigned products from mul_64b.
// Sums a block of products into a guard-extended total and hands it off over a valid/ready port.
module mul_64b_prod_acc #(
    parameter int PW    = 128,
    parameter int GUARD = 8,
    parameter int LEN_W = 8,
    localparam int SW   = PW + GUARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in0,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SW-1:0]    out0,
    output logic [LEN_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state, state_nx;
    logic [SW-1:0]    acc, acc_nx;
    logic [LEN_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic             ovf, ovf_nx;
    logic             take;
    logic [SW:0]      sum;
    logic [LEN_W-1:0] first_len;
    logic [LEN_W-1:0] cnt_inc;

    // A zero length field still describes a one-product block.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    assign in_ready  = (state != HOLD) && !rst;
    assign take      = in_valid && in_ready;
    assign sum       = {1'b0, acc} + {{(GUARD + 1){1'b0}}, in0};
    assign first_len = eff_len(in_len);
    assign cnt_inc   = cnt + LEN_W'(1);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        len_nx   = len;
        ovf_nx   = ovf;
        case (state)
            IDLE: begin
                if (take) begin
                    acc_nx   = {{GUARD{1'b0}}, in0};
                    cnt_nx   = LEN_W'(1);
                    ovf_nx   = 1'b0;
                    len_nx   = first_len;
                    state_nx = (first_len == LEN_W'(1)) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (take) begin
                    acc_nx = sum[SW-1:0];
                    ovf_nx = ovf | sum[SW];
                    cnt_nx = cnt_inc;
                    if (cnt_inc == len) begin
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            len   <= len_nx;
            ovf   <= ovf_nx;
        end
    end

    // The sum registers are only written while accepting beats, so they are stable throughout HOLD.
    assign out_valid = (state == HOLD);
    assign out0      = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_mul_64b_prod_acc.sv
// Randomized bench for mul_64b_prod_acc: block sums checked every cycle against a plain-arithmetic model.
module tb_mul_64b_prod_acc;

    localparam int PW    = 128;
    localparam int GUARD = 8;
    localparam int LEN_W = 8;
    localparam int SW    = PW + GUARD;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PW-1:0]    in0 = '0;
    logic [LEN_W-1:0] in_len = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [SW-1:0]    out0;
    logic [LEN_W-1:0] out_count;
    logic             out_ovf;

    always #5 clk = ~clk;

    mul_64b_prod_acc #(.PW(PW), .GUARD(GUARD), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in0(in0), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out_count(out_count), .out_ovf(out_ovf)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: a block is a list of accepted products; its total is kept exactly in 256 bits.
    bit           m_hold   = 1'b0;
    bit           m_active = 1'b0;
    bit           m_clean  = 1'b1;
    logic [255:0] m_total  = '0;
    int           m_cnt    = 0;
    int           m_len    = 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [PW-1:0] d,
                        input logic [LEN_W-1:0] l, input bit ordy);
        rst = r; in_valid = v; in0 = d; in_len = l; out_ready = ordy;
        if (r) begin
            m_hold = 1'b0; m_active = 1'b0; m_clean = 1'b1; m_total = '0; m_cnt = 0;
        end else if (m_hold) begin
            if (ordy) m_hold = 1'b0;
        end else if (v) begin
            if (!m_active) begin
                m_len    = (l == '0) ? 1 : int'(l);
                m_total  = 256'(d);
                m_cnt    = 1;
                m_active = 1'b1;
            end else begin
                m_total = m_total + 256'(d);
                m_cnt++;
            end
            m_clean = 1'b0;
            if (m_cnt == m_len) begin
                m_hold = 1'b1; m_active = 1'b0;
            end
        end
        @(negedge clk);
        chk("in_ready", 256'(in_ready), 256'(!m_hold && !r));
        chk("out_valid", 256'(out_valid), 256'(m_hold));
        if (m_hold || m_clean) begin
            chk("out0", 256'(out0), m_hold ? 256'(m_total[SW-1:0]) : 256'(0));
            chk("out_count", 256'(out_count), m_hold ? 256'(m_cnt) : 256'(0));
            chk("out_ovf", 256'(out_ovf), m_hold ? 256'(|m_total[255:SW]) : 256'(0));
        end
    endtask

    logic [PW-1:0]    ones;
    logic [SW-1:0]    held;
    logic [63:0]      a, b;
    logic [PW-1:0]    p;
    logic [LEN_W-1:0] l;
    bit               r, v, o;

    initial begin
        ones = '1;
        @(negedge clk);

        // Reset for two cycles, then idle.
        step(1, 0, '0, '0, 0);
        step(1, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0);
        chk("t1_in_ready", 256'(in_ready), 256'(1));
        chk("t1_out_valid", 256'(out_valid), 256'(0));
        chk("t1_out0", 256'(out0), 256'(0));
        chk("t1_out_count", 256'(out_count), 256'(0));

        // len=3, beats 5, 7, 11.
        step(0, 1, 128'd5, 8'd3, 1);
        step(0, 1, 128'd7, 8'd0, 1);
        chk("t2_not_yet", 256'(out_valid), 256'(0));
        step(0, 1, 128'd11, 8'd0, 1);
        chk("t2_out_valid", 256'(out_valid), 256'(1));
        chk("t2_out0", 256'(out0), 256'(23));
        chk("t2_out_count", 256'(out_count), 256'(3));
        chk("t2_out_ovf", 256'(out_ovf), 256'(0));
        step(0, 0, '0, '0, 1);
        chk("t2_released", 256'(out_valid), 256'(0));

        // len=0 is a one-product block.
        step(0, 1, ones, 8'd0, 0);
        chk("t3_out0", 256'(out0), 256'(ones));
        chk("t3_out_count", 256'(out_count), 256'(1));
        step(0, 0, '0, '0, 1);

        // 255 all-ones products exercise the guard bits.
        for (int i = 0; i < 255; i++) step(0, 1, ones, 8'd255, 0);
        chk("t4_out0", 256'(out0), 256'(136'hFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF01));
        chk("t4_out_count", 256'(out_count), 256'(255));
        chk("t4_out_ovf", 256'(out_ovf), 256'(0));

        // Back-pressure while the result waits.
        held = out0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 128'd42, 8'd1, 0);
            chk("t5_in_ready", 256'(in_ready), 256'(0));
            chk("t5_out0_stable", 256'(out0), 256'(held));
        end
        step(0, 1, 128'd42, 8'd1, 1);
        chk("t5_after_hs_valid", 256'(out_valid), 256'(0));
        chk("t5_after_hs_ready", 256'(in_ready), 256'(1));
        step(0, 1, 128'd42, 8'd1, 0);
        chk("t5_beat_taken", 256'(out_valid), 256'(1));
        chk("t5_out0", 256'(out0), 256'(42));
        step(0, 0, '0, '0, 1);

        // Reset mid-block discards the partial sum.
        step(0, 1, 128'd100, 8'd4, 0);
        step(0, 1, 128'd200, 8'd0, 0);
        step(1, 0, '0, '0, 0);
        step(0, 1, 128'd9, 8'd1, 0);
        chk("t6_out0", 256'(out0), 256'(9));
        chk("t6_out_count", 256'(out_count), 256'(1));
        step(0, 0, '0, '0, 1);

        // Random products from 64x64 operand pairs with random stalls.
        for (int i = 0; i < 3000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            p = {64'd0, a} * {64'd0, b};
            if ($urandom_range(0, 15) == 0) p = ones;
            l = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            step(r, v, p, l, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
